// File: rtl/som_result_reader.sv
// som_result_reader
// Drains the SOM engine's memories once training is done: reads all weight
// RAM words, then all result RAM words, through each RAM's read port and
// streams them in order over a valid/ready output. A 2-entry output FIFO plus
// at most one read in flight lets reads run at one word per cycle while
// never overrunning the buffer under backpressure.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-low reset
//   start              level from the controller's done signal
//   RAM_W_A/OE/Q       weight RAM read port (Q valid the cycle after OE)
//   RAM_RESULT_A/OE/Q  result RAM read port (Q valid the cycle after OE)
//   out_valid/ready    output handshake, word moves when both are high
//   out_data           output word
//   out_sel            0 = weight word, 1 = result word
//   out_last           marks the final result word
//   busy               reading or draining
//   finish             all words delivered, waiting for start to drop
module som_result_reader #(
  parameter int DW      = 24,
  parameter int AW      = 18,
  parameter int W_DEPTH = 64,
  parameter int R_DEPTH = 20480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] RAM_W_A,
  output logic          RAM_W_OE,
  input  logic [DW-1:0] RAM_W_Q,
  output logic [AW-1:0] RAM_RESULT_A,
  output logic          RAM_RESULT_OE,
  input  logic [DW-1:0] RAM_RESULT_Q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sel,
  output logic          out_last,
  output logic          busy,
  output logic          finish
);

  typedef enum logic [2:0] {IDLE, RD_W, RD_R, DRAIN, FIN} state_t;

  localparam logic [AW-1:0] W_LAST = AW'(W_DEPTH - 1);
  localparam logic [AW-1:0] R_LAST = AW'(R_DEPTH - 1);

  state_t        state, state_next;
  logic [AW-1:0] cnt, cnt_next;

  // FIFO entry layout: {last, sel, data}
  logic [DW+1:0] fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_count;
  logic [DW+1:0] head;

  logic          inflight, inflight_sel, inflight_last;
  logic [1:0]    occupancy;
  logic          pop, push, issue;
  logic [DW-1:0] push_data;

  // Credit check: buffered words plus the read in flight may never exceed
  // the FIFO depth, but a pop this cycle frees a slot for a read right away,
  // which is what keeps full-rate streaming under out_ready=1.
  always_comb begin
    head      = fifo_mem[rd_ptr];
    pop       = (fifo_count != 2'd0) && out_ready;
    push      = inflight;
    push_data = inflight_sel ? RAM_RESULT_Q : RAM_W_Q;
    occupancy = fifo_count + {1'b0, inflight};
    issue     = ((state == RD_W) || (state == RD_R)) &&
                ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
  end

  // Next-state and address counter; each read phase ends on the cycle that
  // issues its final address.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (start) state_next = RD_W;
      end
      RD_W: begin
        if (issue) begin
          if (cnt == W_LAST) begin
            state_next = RD_R;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + AW'(1);
          end
        end
      end
      RD_R: begin
        if (issue) begin
          if (cnt == R_LAST) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + AW'(1);
          end
        end
      end
      DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight) state_next = FIN;
      end
      FIN: begin
        if (!start) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Read ports and status; head fields are masked so an empty FIFO shows 0.
  always_comb begin
    RAM_W_OE      = issue && (state == RD_W);
    RAM_W_A       = (state == RD_W) ? cnt : '0;
    RAM_RESULT_OE = issue && (state == RD_R);
    RAM_RESULT_A  = (state == RD_R) ? cnt : '0;
    out_valid     = (fifo_count != 2'd0);
    out_data      = out_valid ? head[DW-1:0] : '0;
    out_sel       = out_valid ? head[DW] : 1'b0;
    out_last      = out_valid ? head[DW+1] : 1'b0;
    busy          = (state == RD_W) || (state == RD_R) || (state == DRAIN);
    finish        = (state == FIN);
  end

  // Control state; clearing inflight on reset discards RAM data still on Q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      inflight      <= 1'b0;
      inflight_sel  <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_count    <= 2'd0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      inflight      <= issue;
      inflight_sel  <= (state == RD_R);
      inflight_last <= (state == RD_R) && (cnt == R_LAST);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count    <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: fifo_count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {inflight_last, inflight_sel, push_data};
  end

endmodule

// File: tb/tb_som_result_reader.sv
// tb_som_result_reader
// Bench for som_result_reader. Two behavioural RAMs return
// 0x100000+address (weights) and address (results) one cycle after OE and
// random garbage otherwise. The expected stream is computed from the word
// index alone: weights 0..63 then results 0..20479, last on the final word.
module tb_som_result_reader;

  localparam int DW      = 24;
  localparam int AW      = 18;
  localparam int W_DEPTH = 64;
  localparam int R_DEPTH = 20480;
  localparam int TOTAL   = W_DEPTH + R_DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] RAM_W_A;
  logic          RAM_W_OE;
  logic [DW-1:0] RAM_W_Q;
  logic [AW-1:0] RAM_RESULT_A;
  logic          RAM_RESULT_OE;
  logic [DW-1:0] RAM_RESULT_Q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sel;
  logic          out_last;
  logic          busy;
  logic          finish;

  logic [2*AW+DW+6:0] all_out;
  assign all_out = {RAM_W_A, RAM_W_OE, RAM_RESULT_A, RAM_RESULT_OE, out_valid,
                    out_data, out_sel, out_last, busy, finish};

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;
  int issue_idx = 0;

  som_result_reader #(
    .DW(DW), .AW(AW), .W_DEPTH(W_DEPTH), .R_DEPTH(R_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .RAM_W_A(RAM_W_A), .RAM_W_OE(RAM_W_OE), .RAM_W_Q(RAM_W_Q),
    .RAM_RESULT_A(RAM_RESULT_A), .RAM_RESULT_OE(RAM_RESULT_OE),
    .RAM_RESULT_Q(RAM_RESULT_Q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_last(out_last), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAMs; Q is junk in any cycle not following an OE.
  always @(posedge clk) begin
    RAM_W_Q      <= RAM_W_OE ? DW'(32'h100000 + 32'(RAM_W_A)) : DW'($urandom);
    RAM_RESULT_Q <= RAM_RESULT_OE ? DW'(RAM_RESULT_A) : DW'($urandom);
  end

  function automatic logic [DW-1:0] model_data(input int k);
    if (k < W_DEPTH) return DW'(32'h100000 + k);
    return DW'(k - W_DEPTH);
  endfunction

  task automatic finish_summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // One clock: drive out_ready, then score issued reads and popped words.
  task automatic tick(input int ready_pct);
    logic          exp_w;
    logic [AW-1:0] exp_a;
    logic [AW-1:0] got_a;
    logic          issued;
    @(posedge clk);
    #1;
    out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    #1;
    issued = 1'b0;
    n_checks++;
    if (RAM_W_OE && RAM_RESULT_OE) begin
      n_fail++;
      $display("[TB] FAIL both_oe: W_OE=%b RESULT_OE=%b, required not both 1", RAM_W_OE, RAM_RESULT_OE);
    end
    if (RAM_W_OE || RAM_RESULT_OE) begin
      issued = 1'b1;
      exp_w  = (issue_idx < W_DEPTH);
      exp_a  = exp_w ? AW'(issue_idx) : AW'(issue_idx - W_DEPTH);
      got_a  = RAM_W_OE ? RAM_W_A : RAM_RESULT_A;
      n_checks++;
      if (issue_idx >= TOTAL || RAM_W_OE !== exp_w || got_a !== exp_a) begin
        n_fail++;
        $display("[TB] FAIL read_issue #%0d: W_OE=%b addr=%0d, required W_OE=%b addr=%0d",
                 issue_idx, RAM_W_OE, got_a, exp_w, exp_a);
      end
      issue_idx++;
    end
    if (out_valid === 1'b1 && out_ready) begin
      n_checks++;
      if (exp_idx >= TOTAL || out_data !== model_data(exp_idx) ||
          out_sel !== (exp_idx >= W_DEPTH) || out_last !== (exp_idx == TOTAL - 1)) begin
        n_fail++;
        $display("[TB] FAIL beat #%0d: data=%h sel=%b last=%b, required data=%h sel=%b last=%b",
                 exp_idx, out_data, out_sel, out_last, model_data(exp_idx),
                 exp_idx >= W_DEPTH, exp_idx == TOTAL - 1);
      end
      exp_idx++;
    end
    if (issued) begin
      n_checks++;
      if (issue_idx - exp_idx > 2) begin
        n_fail++;
        $display("[TB] FAIL outstanding: %0d words issued but not taken, required <= 2",
                 issue_idx - exp_idx);
      end
    end
    if (n_fail > 40) begin
      $display("[TB] too many errors, stopping early");
      finish_summary();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      n_checks++;
      if (all_out !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs cycle %0d: outputs=%h, required all zero", i, all_out);
      end
    end
    rst = 1'b1;
    exp_idx = 0;
    issue_idx = 0;
    tick(100);
    n_checks++;
    if (busy !== 1'b1 || RAM_W_OE !== 1'b1 || RAM_W_A !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: busy=%b W_OE=%b W_A=%0d, required 1 1 0", busy, RAM_W_OE, RAM_W_A);
    end
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #2;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_with_read_in_flight: outputs=%h, required all zero", all_out);
    end
    rst = 1'b1;
    @(posedge clk);
    #2;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_discard: busy=%b out_valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_free_flow();
    int first_valid = -1;
    int last_cycle  = -1;
    int fin_cycle   = -1;
    int gaps        = 0;
    exp_idx = 0;
    issue_idx = 0;
    start = 1'b1;
    for (int c = 1; c <= TOTAL + 20; c++) begin
      tick(100);
      if (out_valid && first_valid < 0) first_valid = c;
      if (first_valid >= 0 && last_cycle < 0 && !out_valid) gaps++;
      if (out_last && last_cycle < 0) last_cycle = c;
      if (finish) begin
        fin_cycle = c;
        break;
      end
    end
    n_checks++;
    if (first_valid != 3) begin
      n_fail++;
      $display("[TB] FAIL first_valid_latency: %0d cycles, required 3", first_valid);
    end
    n_checks++;
    if (gaps != 0) begin
      n_fail++;
      $display("[TB] FAIL free_flow_gaps: %0d bubbles, required 0", gaps);
    end
    n_checks++;
    if (exp_idx != TOTAL || issue_idx != TOTAL) begin
      n_fail++;
      $display("[TB] FAIL free_flow_count: beats=%0d reads=%0d, required %0d", exp_idx, issue_idx, TOTAL);
    end
    n_checks++;
    if (last_cycle != 3 + TOTAL - 1) begin
      n_fail++;
      $display("[TB] FAIL last_cycle: %0d, required %0d", last_cycle, 3 + TOTAL - 1);
    end
    n_checks++;
    if (fin_cycle < 0 || fin_cycle != last_cycle + 2) begin
      n_fail++;
      $display("[TB] FAIL finish_cycle: %0d, required %0d", fin_cycle, last_cycle + 2);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_in_fin: %b, required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int issued_before;
    start = 1'b0;
    tick(100);
    n_checks++;
    if (finish !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL back_to_idle: finish=%b busy=%b, required 0 0", finish, busy);
    end
    exp_idx = 0;
    issue_idx = 0;
    start = 1'b1;
    for (int c = 0; c < 200 && exp_idx < 30; c++) tick(100);
    n_checks++;
    if (exp_idx != 30) begin
      n_fail++;
      $display("[TB] FAIL reach_word30: %0d words taken, required 30", exp_idx);
    end
    issued_before = issue_idx;
    for (int c = 1; c <= 10; c++) begin
      tick(0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== model_data(30) || out_sel !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_hold cycle %0d: valid=%b data=%h sel=%b, required 1 %h 0",
                 c, out_valid, out_data, out_sel, model_data(30));
      end
      if (c >= 3) begin
        n_checks++;
        if (RAM_W_OE !== 1'b0 || RAM_RESULT_OE !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stall_oe cycle %0d: W_OE=%b RESULT_OE=%b, required 0 0", c, RAM_W_OE, RAM_RESULT_OE);
        end
      end
    end
    n_checks++;
    if (issue_idx - issued_before > 2 || issue_idx - exp_idx != 2) begin
      n_fail++;
      $display("[TB] FAIL stall_buffer: %0d reads during stall, %0d outstanding, required <=2 and 2",
               issue_idx - issued_before, issue_idx - exp_idx);
    end
    for (int c = 1; c <= 5; c++) begin
      tick(100);
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL resume_gap cycle %0d: out_valid=%b, required 1", c, out_valid);
      end
    end
  endtask

  task automatic test_random_ready();
    for (int c = 0; c < 1500; c++) tick(50);
    n_checks++;
    if (exp_idx <= W_DEPTH + 10) begin
      n_fail++;
      $display("[TB] FAIL random_progress: %0d words taken, required > %0d", exp_idx, W_DEPTH + 10);
    end
  endtask

  task automatic test_mid_reset();
    int fin_seen = 0;
    for (int c = 0; c < 8000 && exp_idx < W_DEPTH + 5000; c++) tick(100);
    n_checks++;
    if (exp_idx != W_DEPTH + 5000) begin
      n_fail++;
      $display("[TB] FAIL reach_result5000: %0d words taken, required %0d", exp_idx, W_DEPTH + 5000);
    end
    rst = 1'b0;
    @(posedge clk);
    #2;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_outputs: outputs=%h, required all zero", all_out);
    end
    rst = 1'b1;
    exp_idx = 0;
    issue_idx = 0;
    for (int c = 0; c < TOTAL + 20; c++) begin
      tick(100);
      if (finish) begin
        fin_seen = 1;
        break;
      end
    end
    n_checks++;
    if (fin_seen != 1 || exp_idx != TOTAL) begin
      n_fail++;
      $display("[TB] FAIL restart_run: finished=%0d beats=%0d, required 1 %0d", fin_seen, exp_idx, TOTAL);
    end
  endtask

  task automatic test_fin_hold();
    int fin_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(100);
      n_checks++;
      if (finish !== 1'b1 || RAM_W_OE !== 1'b0 || RAM_RESULT_OE !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL fin_hold cycle %0d: finish=%b W_OE=%b RESULT_OE=%b valid=%b, required 1 0 0 0",
                 c, finish, RAM_W_OE, RAM_RESULT_OE, out_valid);
      end
    end
    start = 1'b0;
    tick(100);
    n_checks++;
    if (finish !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fin_release: finish=%b, required 0", finish);
    end
    exp_idx = 0;
    issue_idx = 0;
    start = 1'b1;
    for (int c = 0; c < TOTAL + 20; c++) begin
      tick(100);
      if (finish) begin
        fin_seen = 1;
        break;
      end
    end
    n_checks++;
    if (fin_seen != 1 || exp_idx != TOTAL || issue_idx != TOTAL) begin
      n_fail++;
      $display("[TB] FAIL second_run: finished=%0d beats=%0d reads=%0d, required 1 %0d %0d",
               fin_seen, exp_idx, issue_idx, TOTAL, TOTAL);
    end
  endtask

  // Hard bound on total simulated time in case the design never finishes.
  initial begin
    #1000000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    finish_summary();
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_free_flow();
    test_backpressure();
    test_random_ready();
    test_mid_reset();
    test_fin_hold();
    finish_summary();
  end

endmodule
